// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the fifo read port: fetches one word per frame and
// serialises it as start, LSB-first data, optional even parity and stop bits.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_rd_val,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q;
  state_t                  state_n;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_n;
  logic [BIT_W-1:0]        bit_q;
  logic [BIT_W-1:0]        bit_n;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    parity_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tx_n;
  logic                    busy_n;
  logic                    done_n;
  logic                    cnt_last;
  logic                    bit_val;

  assign fifo_rd_en = (state_q == S_IDLE) & en & fifo_rd_val & reset;
  assign cnt_last   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Next state, baud counter and bit index; the counter restarts on every state entry.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    bit_n   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (fifo_rd_en) begin
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = S_START;
      end
      S_START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_n   = '0;
            state_n = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_n   = '0;
            state_n = S_IDLE;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered line lines up with it.
  always_comb begin
    bit_val = 1'b0;
    tx_n    = 1'b1;
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_STOP) && (bit_n == BIT_W'(STOP_BITS - 1)) &&
              (cnt_n == CNT_W'(CLKS_PER_BIT - 1));
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_n == BIT_W'(i)) begin
        bit_val = shift_q[i];
      end
    end
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = bit_val;
      S_PARITY: tx_n = parity_q;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
    end
  end

  // Read data is only meaningful in the cycle after the read, i.e. while in FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (state_q == S_FETCH) begin
        shift_q  <= fifo_rd_data;
        parity_q <= ^fifo_rd_data;
      end
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model feeds the default DUT,
// a second instance with parity enabled is driven directly.
module tb_fifo_uart_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;

  typedef struct {
    logic [7:0]  word;
    logic [10:0] frame;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          fifo_gate;
  logic          fifo_rd_val;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;

  logic          p_en;
  logic          p_rd_val;
  logic [DW-1:0] p_rd_data;
  logic          p_rd_en;
  logic          p_tx;
  logic          p_busy;
  logic          p_frame_done;

  logic [DW-1:0] fq [64];
  int            wr_ptr    = 0;
  int            rd_ptr    = 0;
  int            rd_pulses = 0;
  int            n_checks  = 0;
  int            n_pass    = 0;

  vec_t          vecs  [5];
  vec_t          pvecs [2];

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .fifo_rd_val  (fifo_rd_val),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk          (clk),
    .reset        (reset),
    .en           (p_en),
    .fifo_rd_val  (p_rd_val),
    .fifo_rd_data (p_rd_data),
    .fifo_rd_en   (p_rd_en),
    .tx           (p_tx),
    .busy         (p_busy),
    .frame_done   (p_frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_rd_val = fifo_gate && (rd_ptr != wr_ptr);

  // FIFO model: read data appears the cycle after an accepted read, junk otherwise.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fq[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
      rd_pulses    <= rd_pulses + 1;
    end else begin
      fifo_rd_data <= 8'h96;
    end
  end

  task automatic check(input bit ok, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
  endtask

  task automatic push(input logic [7:0] w);
    fq[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic expect_line(input string what, input logic e_tx, input logic e_busy,
                             input logic e_rd);
    check({tx, busy, fifo_rd_en} === {e_tx, e_busy, e_rd}, what,
          32'({tx, busy, fifo_rd_en}), 32'({e_tx, e_busy, e_rd}));
  endtask

  // Call so that the next falling edge lands in the first start-bit cycle.
  task automatic check_frame(input logic [10:0] exp, input int nbits, input bit par,
                             input int drop_at, input string name);
    int  fd_cnt;
    int  fd_pos;
    int  match;
    bit  busy_ok;
    logic t;
    fd_cnt  = 0;
    fd_pos  = -1;
    busy_ok = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      match = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        t = par ? p_tx : tx;
        if (t === exp[b]) match++;
        if ((par ? p_frame_done : frame_done) === 1'b1) begin
          fd_cnt++;
          fd_pos = b * int'(CPB) + c;
        end
        if ((par ? p_busy : busy) !== 1'b1) busy_ok = 1'b0;
        if (b * int'(CPB) + c == drop_at) en = 1'b0;
      end
      check(match == int'(CPB), $sformatf("%s_bit%0d", name, b), 32'(match), 32'(CPB));
    end
    check(fd_cnt == 1 && fd_pos == nbits * int'(CPB) - 1, {name, "_frame_done_pos"},
          32'(fd_pos), 32'(nbits * int'(CPB) - 1));
    check(busy_ok, {name, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int  base;
    bit  ok;
    vecs[0]  = '{8'h01, 11'h202};
    vecs[1]  = '{8'h02, 11'h204};
    vecs[2]  = '{8'h03, 11'h206};
    vecs[3]  = '{8'hFF, 11'h3FE};
    vecs[4]  = '{8'h00, 11'h200};
    pvecs[0] = '{8'hA5, 11'h54A};
    pvecs[1] = '{8'h07, 11'h60E};

    reset     = 1'b0;
    en        = 1'b1;
    fifo_gate = 1'b1;
    p_en      = 1'b1;
    p_rd_val  = 1'b0;
    p_rd_data = '0;
    push(8'hA5);

    // reset held with data available
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tx, busy, fifo_rd_en, frame_done} === 4'b1000, $sformatf("reset_hold%0d", i),
            32'({tx, busy, fifo_rd_en, frame_done}), 32'h8);
    end
    reset = 1'b1;
    #1;
    check(fifo_rd_en === 1'b1, "rd_en_after_reset", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("a5_fetch", 1'b1, 1'b1, 1'b0);
    check_frame(11'h34A, 10, 1'b0, -1, "a5");
    @(negedge clk);
    expect_line("a5_idle", 1'b1, 1'b0, 1'b0);
    check(rd_pulses == 1, "a5_rd_pulses", 32'(rd_pulses), 32'd1);

    // back-to-back frames from the table
    fifo_gate = 1'b0;
    foreach (vecs[i]) push(vecs[i].word);
    base = rd_pulses;
    @(negedge clk);
    fifo_gate = 1'b1;
    #1;
    check(fifo_rd_en === 1'b1, "b2b_first_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("b2b_fetch0", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_frame(vecs[i].frame, 10, 1'b0, -1, $sformatf("b2b%0d", i));
      if (i < 4) begin
        @(negedge clk);
        expect_line($sformatf("b2b_gap_idle%0d", i), 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        expect_line($sformatf("b2b_gap_fetch%0d", i), 1'b1, 1'b1, 1'b0);
      end
    end
    @(negedge clk);
    expect_line("b2b_end_idle", 1'b1, 1'b0, 1'b0);
    check(rd_pulses - base == 5, "b2b_rd_pulses", 32'(rd_pulses - base), 32'd5);

    // empty FIFO: nothing happens
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({tx, busy, fifo_rd_en} !== 3'b100) ok = 1'b0;
    end
    check(ok, "empty_50", 32'(ok), 32'd1);

    // enable dropped during data bits of 0x3C
    push(8'h3C);
    push(8'h11);
    #1;
    check(fifo_rd_en === 1'b1, "en_rd_3c", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("en_fetch_3c", 1'b1, 1'b1, 1'b0);
    check_frame(11'h278, 10, 1'b0, 10, "en_3c");
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx, busy, fifo_rd_en} !== 3'b100) ok = 1'b0;
    end
    check(ok, "en_low_no_fetch", 32'(ok), 32'd1);
    en = 1'b1;
    #1;
    check(fifo_rd_en === 1'b1, "en_rd_11", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("en_fetch_11", 1'b1, 1'b1, 1'b0);
    check_frame(11'h222, 10, 1'b0, -1, "en_11");

    // reset during data bit 3 of 0xFF
    @(negedge clk);
    push(8'hFF);
    push(8'h81);
    base = rd_pulses;
    #1;
    check(fifo_rd_en === 1'b1, "rst_rd_ff", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("rst_fetch_ff", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) @(negedge clk);
    expect_line("rst_ff_bit3", 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check({tx, busy, fifo_rd_en, frame_done} === 4'b1000, "rst_mid_frame",
          32'({tx, busy, fifo_rd_en, frame_done}), 32'h8);
    reset = 1'b1;
    #1;
    check(fifo_rd_en === 1'b1, "rst_rd_81", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    expect_line("rst_fetch_81", 1'b1, 1'b1, 1'b0);
    check_frame(11'h302, 10, 1'b0, -1, "rst_81");
    @(negedge clk);
    check(rd_pulses - base == 2, "rst_rd_pulses", 32'(rd_pulses - base), 32'd2);

    // parity instance
    foreach (pvecs[i]) begin
      @(negedge clk);
      p_rd_data = pvecs[i].word;
      p_rd_val  = 1'b1;
      #1;
      check(p_rd_en === 1'b1, $sformatf("par%0d_rd", i), 32'(p_rd_en), 32'd1);
      @(negedge clk);
      p_rd_val = 1'b0;
      check({p_tx, p_busy} === 2'b11, $sformatf("par%0d_fetch", i),
            32'({p_tx, p_busy}), 32'h3);
      check_frame(pvecs[i].frame, 11, 1'b1, -1, $sformatf("par%0d", i));
      @(negedge clk);
      check({p_tx, p_busy} === 2'b10, $sformatf("par%0d_idle", i),
            32'({p_tx, p_busy}), 32'h2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the team's `fifo` block.
- Pulls words from the FIFO read port with the rd_en/rd_val handshake and serialises each word onto a UART line.
- Frame format: one start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
- Sits between the FIFO and the chip TX pin.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of the serial payload.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 = insert an even parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  transmit enable; when low, no new word is fetched.
- fifo_rd_val  input  1  FIFO has data (FIFO rd_val).
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid in the cycle after a read was accepted.
- fifo_rd_en  output  1  read request to the FIFO (FIFO rd_en).
- tx  output  1  serial line; idles high.
- busy  output  1  high from fetch until the end of the last stop bit.
- frame_done  output  1  one-cycle pulse in the last cycle of the last stop bit.

Behaviour:
- Reset (reset==0 at a clock edge) forces, on that edge:
  - state IDLE, tx=1, busy=0, frame_done=0;
  - baud counter=0, bit index=0, shift register=0.
- fifo_rd_en is combinational: (state==IDLE) & en & fifo_rd_val & reset. It is never high outside IDLE and never high while reset is low.
- States and transitions:
  - IDLE: tx=1, busy=0. If fifo_rd_en is high, go to FETCH.
  - FETCH (1 cycle): capture shift_reg <= fifo_rd_data; compute parity as XOR of fifo_rd_data; go to START. busy=1, tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift_reg[bit index] for CLKS_PER_BIT cycles per bit, LSB first. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Then go to IDLE.
- tx is a registered output: it changes only on clock edges and is glitch-free.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary;
  - width is $clog2(CLKS_PER_BIT)+1;
  - cleared on every state entry.
- Latency:
  - fifo_rd_en high in cycle T → FETCH in T+1 → tx first low in cycle T+2.
  - Frame length is (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from the first low cycle.
- Back-to-back words:
  - After STOP, IDLE is re-entered; if en & fifo_rd_val, the next read issues in that IDLE cycle.
  - Inter-frame gap is exactly 2 extra idle-high cycles (IDLE + FETCH) beyond the stop bits.
- en deasserted mid-frame: the current frame completes unchanged; no further fetch while en is low.
- fifo_rd_val low in IDLE: stay in IDLE, tx=1, fifo_rd_en=0. This is the empty boundary; no read is ever issued to an empty FIFO.
- fifo_rd_data is sampled only in FETCH; its value in any other cycle is ignored.
- Reset mid-frame:
  - tx returns to 1 and state returns to IDLE on that edge;
  - the word in flight is dropped, not re-read;
  - fifo_rd_en is low during reset.
- busy is high in the FETCH, START, DATA, PARITY and STOP states.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles with fifo_rd_val=1 and en=1 → tx=1, busy=0, fifo_rd_en=0 throughout; the first fifo_rd_en appears in the first cycle after reset rises.
- Single word, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, word 0xA5:
  - tx from T+2 is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total);
  - frame_done pulses in cycle T+41;
  - exactly one fifo_rd_en pulse.
- Parity, PARITY_EN=1: word 0xA5 → parity bit 0; word 0x07 → parity bit 1. Frame is 44 cycles.
- Back-to-back: FIFO preloaded with 0x01, 0x02, 0x03, fifo_rd_val held high → three frames, each separated by exactly 2 idle-high cycles; 3 fifo_rd_en pulses total.
- Empty and enable boundaries:
  - fifo_rd_val=0 for 50 cycles → tx=1 and no fifo_rd_en.
  - en dropped in the middle of the DATA bits of word 0x3C → frame completes correctly and no new fetch while en=0.
- Reset mid-frame: assert reset=0 during data bit 3 of 0xFF → tx=1 on the next edge, state IDLE; the next frame after reset carries the next FIFO word, not 0xFF.
